// File: rtl/zoom_scheduler.sv
// Command-level controller for the zoom pipeline: holds the view state (zoom level and pan
// offsets), launches the render engine for the current level and muxes its RAM ports onto the frame memory.
module zoom_scheduler #(
  parameter int unsigned SRC_W       = 160,
  parameter int unsigned SRC_H       = 120,
  parameter int unsigned PAN_STEP    = 8,
  parameter int unsigned TIMEOUT_CYC = 131072
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  output logic        cmd_ready,
  output logic [1:0]  eng_start,
  input  logic [1:0]  eng_done,
  input  logic [33:0] eng_rd_addr,
  input  logic [33:0] eng_wr_addr,
  input  logic [15:0] eng_wr_data,
  input  logic [1:0]  eng_wren,
  output logic [16:0] mem_rd_addr,
  output logic [16:0] mem_wr_addr,
  output logic [7:0]  mem_wr_data,
  output logic        mem_wren,
  output logic [7:0]  offset_x,
  output logic [7:0]  offset_y,
  output logic        zoom_level,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_LAUNCH, S_RUN, S_FINISH} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_RESET_VIEW, OP_ZOOM_IN, OP_ZOOM_OUT, OP_PAN_L, OP_PAN_R, OP_PAN_U, OP_PAN_D
  } op_t;

  localparam int unsigned WD_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0] STEP9    = 9'(PAN_STEP);
  localparam logic [8:0] MAX_X9   = 9'(SRC_W);
  localparam logic [8:0] MAX_Y9   = 9'(SRC_H);
  localparam logic [7:0] CENTER_X = 8'(SRC_W / 2);
  localparam logic [7:0] CENTER_Y = 8'(SRC_H / 2);

  state_t          state;
  op_t             op_q;
  logic [WD_W-1:0] wdog;

  logic       nxt_level;
  logic [7:0] nxt_x, nxt_y;
  logic       render, upd_err;
  logic [8:0] inc_x, dec_x, inc_y, dec_y;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  assign mem_rd_addr = zoom_level ? eng_rd_addr[33:17] : eng_rd_addr[16:0];
  assign mem_wr_addr = zoom_level ? eng_wr_addr[33:17] : eng_wr_addr[16:0];
  assign mem_wr_data = zoom_level ? eng_wr_data[15:8]  : eng_wr_data[7:0];
  assign mem_wren    = (state == S_RUN) && eng_wren[zoom_level];

  // Pan arithmetic is done 9 bits wide so the borrow/carry drives the saturation.
  assign inc_x = {1'b0, offset_x} + STEP9;
  assign dec_x = {1'b0, offset_x} - STEP9;
  assign inc_y = {1'b0, offset_y} + STEP9;
  assign dec_y = {1'b0, offset_y} - STEP9;

  always_comb begin
    nxt_level = zoom_level;
    nxt_x     = offset_x;
    nxt_y     = offset_y;
    render    = 1'b0;
    upd_err   = 1'b0;
    case (op_q)
      OP_RESET_VIEW: begin
        nxt_level = 1'b0;
        nxt_x     = '0;
        nxt_y     = '0;
        render    = 1'b1;
      end
      OP_ZOOM_IN: begin
        if (zoom_level) begin
          upd_err = 1'b1;
        end else begin
          nxt_level = 1'b1;
          nxt_x     = CENTER_X;
          nxt_y     = CENTER_Y;
          render    = 1'b1;
        end
      end
      OP_ZOOM_OUT: begin
        if (!zoom_level) begin
          upd_err = 1'b1;
        end else begin
          nxt_level = 1'b0;
          nxt_x     = '0;
          nxt_y     = '0;
          render    = 1'b1;
        end
      end
      OP_PAN_L: if (zoom_level) nxt_x = dec_x[8] ? '0 : dec_x[7:0];
      OP_PAN_R: if (zoom_level) nxt_x = (inc_x > MAX_X9) ? MAX_X9[7:0] : inc_x[7:0];
      OP_PAN_U: if (zoom_level) nxt_y = dec_y[8] ? '0 : dec_y[7:0];
      OP_PAN_D: if (zoom_level) nxt_y = (inc_y > MAX_Y9) ? MAX_Y9[7:0] : inc_y[7:0];
      default: ;
    endcase
    if (op_q inside {OP_PAN_L, OP_PAN_R, OP_PAN_U, OP_PAN_D})
      render = (nxt_x != offset_x) || (nxt_y != offset_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      wdog       <= '0;
      zoom_level <= 1'b0;
      offset_x   <= '0;
      offset_y   <= '0;
      eng_start  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_t'(cmd_op);
            err   <= 1'b0;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          zoom_level <= nxt_level;
          offset_x   <= nxt_x;
          offset_y   <= nxt_y;
          if (upd_err) err <= 1'b1;
          if (render) begin
            eng_start <= nxt_level ? 2'b10 : 2'b01;
            state     <= S_LAUNCH;
          end else begin
            done  <= 1'b1;
            state <= S_FINISH;
          end
        end
        S_LAUNCH: begin
          eng_start <= '0;
          wdog      <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          // Completion wins over a watchdog expiry in the same cycle.
          if (eng_done[zoom_level]) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (wdog == WD_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
